// File: rtl/squ_acc_tree.sv
// Squeeze-layer reduction: registered pairwise adder tree, multi-beat accumulator,
// FIFO-fed per-kernel bias add, optional ReLU, one DW-bit result per kernel.
module squ_acc_tree #(
  parameter int unsigned LANES      = 8,
  parameter int unsigned DW         = 12,
  parameter int unsigned BW         = 8,
  parameter int unsigned BIAS_SHIFT = 4,
  parameter int unsigned REP_W      = 4,
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          start_i,
  input  logic [REP_W-1:0]              repeat_cnt_i,
  input  logic                          sat_en_i,
  input  logic                          relu_en_i,
  input  logic                          bias_clr_i,
  input  logic                          bias_wr_en_i,
  input  logic [BW-1:0]                 bias_wr_data_i,
  output logic [$clog2(FIFO_DEPTH):0]   bias_count_o,
  output logic                          bias_full_o,
  input  logic [LANES*DW-1:0]           conv_data_i,
  input  logic                          conv_valid_i,
  output logic [DW-1:0]                 output_data_o,
  output logic                          output_valid_o,
  output logic                          bias_underflow_o
);

  localparam int unsigned LEVELS   = $clog2(LANES);
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned NODES    = 2 * LANES - 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  function automatic logic [DW-1:0] fit(input logic [DW:0] s, input logic sat);
    if (sat && (s[DW] != s[DW-1])) fit = {s[DW], {(DW - 1){~s[DW]}}};
    else                           fit = s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] add_fit(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic sat);
    add_fit = fit({a[DW-1], a} + {b[DW-1], b}, sat);
  endfunction

  // Node layout: leaves at [0, LANES), then each tree level packed after the previous.
  function automatic int unsigned lvl_base(input int unsigned s);
    lvl_base = 2 * LANES - ((2 * LANES) >> s);
  endfunction

  logic [DW-1:0]     w_all  [NODES];
  logic [DW-1:0]     r_node [LANES-1];
  logic [LEVELS-1:0] r_tvld;
  logic [LEVELS:0]   w_vin;
  logic [DW-1:0]     w_tree;
  logic              w_tree_vld;

  assign w_vin      = {r_tvld, conv_valid_i};
  assign w_tree     = w_all[NODES-1];
  assign w_tree_vld = r_tvld[LEVELS-1];

  always_comb begin
    w_all = '{default: '0};
    for (int unsigned k = 0; k < LANES; k++) w_all[k] = conv_data_i[DW*k +: DW];
    for (int unsigned j = 0; j < LANES - 1; j++) w_all[LANES+j] = r_node[j];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_node <= '{default: '0};
      r_tvld <= '0;
    end else begin
      for (int unsigned s = 0; s < LEVELS; s++) begin
        r_tvld[s] <= w_vin[s] & ~start_i;
        if (w_vin[s]) begin
          for (int unsigned i = 0; i < (LANES >> (s + 1)); i++)
            r_node[lvl_base(s+1) - LANES + i] <= add_fit(w_all[lvl_base(s) + 2*i],
                                                         w_all[lvl_base(s) + 2*i + 1], sat_en_i);
        end
      end
    end
  end

  logic [DW-1:0]    r_acc;
  logic [REP_W-1:0] r_pass;
  logic             r_afin;
  logic [DW-1:0]    w_acc_sum;
  logic             w_last;

  assign w_last    = (r_pass == repeat_cnt_i);
  assign w_acc_sum = (r_pass == '0) ? w_tree : add_fit(r_acc, w_tree, sat_en_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_acc  <= '0;
      r_pass <= '0;
      r_afin <= 1'b0;
    end else if (start_i) begin
      r_acc  <= '0;
      r_pass <= '0;
      r_afin <= 1'b0;
    end else begin
      r_afin <= w_tree_vld & w_last;
      if (w_tree_vld) begin
        r_acc  <= w_acc_sum;
        r_pass <= w_last ? '0 : r_pass + REP_W'(1);
      end
    end
  end

  logic [BW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_empty, w_full, w_pop, w_do_push, w_do_pop;
  logic [BW-1:0] w_bias_word;
  logic [DW:0]   w_bias_ext;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = r_afin & ~start_i;
  // A pop from an empty FIFO consumes the same-cycle push directly, so that word is never stored.
  assign w_do_push = bias_wr_en_i & ~w_full & ~(w_pop & w_empty);
  assign w_do_pop  = w_pop & ~w_empty;
  assign w_bias_word = w_empty ? (bias_wr_en_i ? bias_wr_data_i : '0) : r_mem[r_rptr];
  assign w_bias_ext  = {{(DW + 1 - BW){w_bias_word[BW-1]}}, w_bias_word} << BIAS_SHIFT;

  assign bias_count_o = r_count;
  assign bias_full_o  = w_full;

  always_ff @(posedge clk_i) begin
    if (w_do_push && !bias_clr_i) r_mem[r_wptr] <= bias_wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (bias_clr_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (AW + 1)'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - (AW + 1)'(1);
    end
  end

  logic [DW-1:0] r_bres;
  logic          r_bvld;
  logic          r_unf;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_bres <= '0;
      r_bvld <= 1'b0;
      r_unf  <= 1'b0;
    end else if (start_i) begin
      r_bvld <= 1'b0;
      r_unf  <= 1'b0;
    end else begin
      r_bvld <= w_pop;
      if (w_pop) r_bres <= fit({r_acc[DW-1], r_acc} + w_bias_ext, sat_en_i);
      if (w_pop && w_empty && !bias_wr_en_i) r_unf <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      output_data_o  <= '0;
      output_valid_o <= 1'b0;
    end else begin
      output_valid_o <= r_bvld & ~start_i;
      if (r_bvld && !start_i)
        output_data_o <= (relu_en_i && r_bres[DW-1]) ? '0 : r_bres;
    end
  end

  assign bias_underflow_o = r_unf;

endmodule

// File: tb/tb_squ_acc_tree.sv
// Directed plus randomized checks of squ_acc_tree against an arithmetic reference model.
module tb_squ_acc_tree;
  localparam int LANES = 8;
  localparam int DW    = 12;
  localparam int BW    = 8;
  localparam int REP_W = 4;
  localparam int CW    = 7;

  typedef int lanes_t [LANES];

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sat_en = 1'b0, relu_en = 1'b0;
  logic bias_clr = 1'b0, bias_wr_en = 1'b0, conv_valid = 1'b0;
  logic [REP_W-1:0]    rep = '0;
  logic [BW-1:0]       bias_data = '0;
  logic [LANES*DW-1:0] conv_data = '0;
  logic [CW-1:0]       bias_count;
  logic                bias_full, out_valid, bias_unf;
  logic [DW-1:0]       out_data;

  int n_assert = 0, n_fail = 0, cyc = 0, drive_cyc = 0;
  int out_q[$], outc_q[$];

  squ_acc_tree #(.LANES(8), .DW(12), .BW(8), .BIAS_SHIFT(4), .REP_W(4), .FIFO_DEPTH(64)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .repeat_cnt_i(rep),
    .sat_en_i(sat_en), .relu_en_i(relu_en), .bias_clr_i(bias_clr),
    .bias_wr_en_i(bias_wr_en), .bias_wr_data_i(bias_data),
    .bias_count_o(bias_count), .bias_full_o(bias_full),
    .conv_data_i(conv_data), .conv_valid_i(conv_valid),
    .output_data_o(out_data), .output_valid_o(out_valid),
    .bias_underflow_o(bias_unf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      out_q.push_back(int'($signed(out_data)));
      outc_q.push_back(cyc);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int fix(int v, bit sat);
    int m;
    if (sat) return (v > 2047) ? 2047 : ((v < -2048) ? -2048 : v);
    m = v & 4095;
    return (m >= 2048) ? m - 4096 : m;
  endfunction

  function automatic int beat_sum(lanes_t lv, bit sat);
    int cur[$];
    int nxt[$];
    foreach (lv[k]) cur.push_back(lv[k]);
    while (cur.size() > 1) begin
      nxt = {};
      for (int i = 0; i < cur.size() / 2; i++) nxt.push_back(fix(cur[2*i] + cur[2*i+1], sat));
      cur = nxt;
    end
    return cur[0];
  endfunction

  function automatic int result_ref(int sums[$], int bias, bit sat, bit relu);
    int acc;
    acc = sums[0];
    for (int i = 1; i < sums.size(); i++) acc = fix(acc + sums[i], sat);
    acc = fix(acc + bias * 16, sat);
    if (relu && acc < 0) acc = 0;
    return acc;
  endfunction

  function automatic int result_one(lanes_t lv, int bias, bit sat, bit relu);
    int q[$];
    q.push_back(beat_sum(lv, sat));
    return result_ref(q, bias, sat, relu);
  endfunction

  function automatic lanes_t all(int v);
    lanes_t r;
    foreach (r[k]) r[k] = v;
    return r;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_bias(input int b);
    bias_wr_en = 1'b1;
    bias_data  = b[BW-1:0];
    tick();
    bias_wr_en = 1'b0;
  endtask

  task automatic send_beat(input lanes_t lv);
    for (int k = 0; k < LANES; k++) begin
      int t;
      t = lv[k];
      conv_data[DW*k +: DW] = t[DW-1:0];
    end
    conv_valid = 1'b1;
    drive_cyc  = cyc;
    tick();
    conv_valid = 1'b0;
  endtask

  task automatic restart(input int r, input bit s, input bit rl);
    rep     = r[REP_W-1:0];
    sat_en  = s;
    relu_en = rl;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int exp, input bit chk_lat);
    int n;
    n = 0;
    while (out_q.size() == 0 && n < 40) begin
      tick();
      n++;
    end
    n_assert++;
    assert (out_q.size() > 0)
      else begin
        n_fail++;
        $error("FAIL %s_timeout: observed no output_valid_o, expected one within 40 cycles", tag);
      end
    if (out_q.size() > 0) begin
      int d;
      int c;
      d = out_q.pop_front();
      c = outc_q.pop_front();
      check(tag, d, exp);
      if (chk_lat) check({tag, "_lat"}, c - drive_cyc, 6);
    end
  endtask

  initial begin
    int bq[$];
    int sums[$];
    lanes_t lv;
    int r, b, v;
    bit s, rl;

    repeat (3) tick();
    check("rst_data", $signed(out_data), 0);
    check("rst_valid", out_valid, 0);
    check("rst_unf", bias_unf, 0);
    check("rst_count", bias_count, 0);
    check("rst_full", bias_full, 0);
    rst_n = 1'b1;
    tick();

    restart(0, 0, 0);
    push_bias(2);
    check("cnt_push", bias_count, 1);
    send_beat(all(1));
    expect_out("basic", 40, 1);
    check("cnt_pop", bias_count, 0);
    check("unf_basic", bias_unf, 0);

    restart(2, 0, 0);
    push_bias(0);
    repeat (3) send_beat(all(5));
    expect_out("rep2", 120, 1);
    repeat (10) tick();
    check("rep2_single", out_q.size(), 0);
    push_bias(0);
    send_beat(all(5));
    send_beat(all(1));
    send_beat(all(1));
    expect_out("rep2_new", 56, 1);

    restart(0, 1, 0);
    push_bias(0);
    send_beat(all(2047));
    expect_out("sat_pos", 2047, 1);
    restart(0, 0, 0);
    push_bias(0);
    send_beat(all(2047));
    expect_out("wrap_pos", result_one(all(2047), 0, 0, 0), 1);
    restart(0, 1, 0);
    push_bias(0);
    send_beat(all(-2048));
    expect_out("sat_neg", -2048, 1);

    restart(0, 0, 1);
    push_bias(0);
    send_beat(all(-3));
    expect_out("relu_on", 0, 1);
    restart(0, 0, 0);
    push_bias(0);
    send_beat(all(-3));
    expect_out("relu_off", -24, 1);

    check("cnt_empty", bias_count, 0);
    restart(0, 0, 0);
    send_beat(all(1));
    expect_out("unf_data", 8, 1);
    check("unf_set", bias_unf, 1);
    repeat (5) tick();
    check("unf_sticky", bias_unf, 1);
    restart(0, 0, 0);
    check("unf_clr", bias_unf, 0);

    send_beat(all(1));
    repeat (3) tick();
    bias_wr_en = 1'b1;
    bias_data  = 8'd5;
    tick();
    bias_wr_en = 1'b0;
    expect_out("bypass", 88, 1);
    check("bypass_unf", bias_unf, 0);
    check("bypass_cnt", bias_count, 0);

    for (int i = 0; i < 64; i++) begin
      b = $urandom_range(0, 255);
      if (b >= 128) b -= 256;
      bq.push_back(b);
      push_bias(b);
    end
    check("fill_full", bias_full, 1);
    check("fill_cnt", bias_count, 64);
    push_bias(99);
    check("drop_cnt", bias_count, 64);
    check("drop_full", bias_full, 1);
    for (int i = 0; i < 64; i++) send_beat(all(0));
    for (int i = 0; i < 64; i++) expect_out("drain", bq[i] * 16, 0);
    check("drain_cnt", bias_count, 0);
    send_beat(all(0));
    expect_out("after_drop", 0, 1);
    check("after_drop_unf", bias_unf, 1);

    restart(1, 0, 0);
    push_bias(0);
    push_bias(0);
    send_beat(all(3));
    send_beat(all(3));
    expect_out("pre_rst", 48, 1);
    send_beat(all(7));
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_data", $signed(out_data), 0);
    check("arst_valid", out_valid, 0);
    check("arst_cnt", bias_count, 0);
    check("arst_unf", bias_unf, 0);
    rep = '0;
    tick();
    rst_n = 1'b1;
    out_q = {};
    outc_q = {};
    tick();
    push_bias(0);
    send_beat(all(1));
    expect_out("post_rst", 8, 1);

    bias_clr = 1'b1;
    tick();
    bias_clr = 1'b0;
    check("clr_cnt", bias_count, 0);

    for (int g = 0; g < 10; g++) begin
      r  = $urandom_range(0, 3);
      s  = 1'($urandom_range(0, 1));
      rl = 1'($urandom_range(0, 1));
      restart(r, s, rl);
      b = $urandom_range(0, 255);
      if (b >= 128) b -= 256;
      push_bias(b);
      sums = {};
      for (int t = 0; t <= r; t++) begin
        for (int k = 0; k < LANES; k++) begin
          if (g % 2 == 0) v = $urandom_range(0, 4095) - 2048;
          else            v = $urandom_range(0, 400) - 200;
          lv[k] = v;
        end
        sums.push_back(beat_sum(lv, s));
        send_beat(lv);
      end
      expect_out("rand", result_ref(sums, b, s, rl), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
